// File: rtl/fixed_p_std_sdiv_pipe.sv
// fixed_p_std_sdiv_pipe
//   Signed fixed-point divider built as an iterative restoring divider.
//   The quotient is (left * 2^FRACT_WIDTH) / right truncated toward zero.
//   One quotient bit is produced per RUN cycle, so a result takes
//   WIDTH+FRACT_WIDTH cycles after the go-sampling edge.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous active-high reset; clears all state and outputs
//   go             start request, only looked at while idle
//   left           signed fixed-point dividend (captured with go)
//   right          signed fixed-point divisor  (captured with go)
//   out_quotient   signed fixed-point quotient, registered, held until next result
//   out_remainder  signed remainder in LSB units of the scaled dividend, registered
//   done           one-cycle pulse that accompanies each new result
//
// Build option
//   FIXED_P_SDIV_SATURATE_EN : when defined, quotient overflow and division by
//   zero saturate the quotient and zero the remainder. When undefined the
//   quotient wraps to its low WIDTH bits and division by zero returns
//   quotient = all ones, remainder = left.
module fixed_p_std_sdiv_pipe #(
  parameter int WIDTH       = 32,
  parameter int INT_WIDTH   = 8,
  parameter int FRACT_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    go,
  input  logic signed [WIDTH-1:0] left,
  input  logic signed [WIDTH-1:0] right,
  output logic signed [WIDTH-1:0] out_quotient,
  output logic signed [WIDTH-1:0] out_remainder,
  output logic                    done
);

  localparam int N     = WIDTH + FRACT_WIDTH;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (INT_WIDTH + FRACT_WIDTH != WIDTH) begin : g_cfg_err
    $error("INT_WIDTH + FRACT_WIDTH must equal WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  // Dividend shifts out of the top while quotient bits shift in at the bottom;
  // after N steps the register holds the full quotient magnitude.
  logic [N-1:0]     dvd_sh;
  logic [WIDTH-1:0] rem;
  logic [WIDTH:0]   dvs;
  logic             neg_q;
  logic             neg_l;
`ifndef FIXED_P_SDIV_SATURATE_EN
  logic [WIDTH-1:0] left_cap;
`endif

  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] rem_nxt;
  logic [N-1:0]     dvd_nxt;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;
  logic             div_zero;

  // Magnitude as an unsigned WIDTH-bit value: |most-negative| = 2^(WIDTH-1)
  // still fits, so the sign is never corrupted.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] ? WIDTH'(-x) : WIDTH'(x);
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] m,
                                                  input logic neg);
    return neg ? -m : m;
  endfunction

`ifdef FIXED_P_SDIV_SATURATE_EN
  // Negative results may reach -2^(WIDTH-1); positive ones stop at 2^(WIDTH-1)-1.
  function automatic logic q_ovf(input logic [N-1:0] m, input logic neg);
    if (neg)
      return (|m[N-1:WIDTH]) || (m[WIDTH-1] && (|m[WIDTH-2:0]));
    else
      return |m[N-1:WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] sat_val(input logic neg);
    return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  // Restoring step: bring in the next dividend bit, subtract if it fits.
  always_comb begin
    trial   = {rem, dvd_sh[N-1]};
    ge      = (trial >= dvs);
    rem_nxt = ge ? WIDTH'(trial - dvs) : trial[WIDTH-1:0];
    dvd_nxt = {dvd_sh[N-2:0], ge};
  end

  assign div_zero = (dvs == '0);

  // Final signed result, registered on the last RUN edge.
`ifdef FIXED_P_SDIV_SATURATE_EN
  always_comb begin
    if (div_zero) begin
      q_res = sat_val(neg_l);
      r_res = '0;
    end else if (q_ovf(dvd_nxt, neg_q)) begin
      q_res = sat_val(neg_q);
      r_res = '0;
    end else begin
      q_res = apply_sign(dvd_nxt[WIDTH-1:0], neg_q);
      r_res = apply_sign(rem_nxt, neg_l);
    end
  end
`else
  always_comb begin
    if (div_zero) begin
      q_res = '1;
      r_res = left_cap;
    end else begin
      q_res = apply_sign(dvd_nxt[WIDTH-1:0], neg_q);
      r_res = apply_sign(rem_nxt, neg_l);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      dvd_sh        <= '0;
      rem           <= '0;
      dvs           <= '0;
      neg_q         <= 1'b0;
      neg_l         <= 1'b0;
`ifndef FIXED_P_SDIV_SATURATE_EN
      left_cap      <= '0;
`endif
      out_quotient  <= '0;
      out_remainder <= '0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // Capture boundary: operands reduced to magnitudes and signs.
        IDLE: begin
          if (go) begin
            state    <= RUN;
            cnt      <= '0;
            dvd_sh   <= {mag(left), {FRACT_WIDTH{1'b0}}};
            rem      <= '0;
            dvs      <= {1'b0, mag(right)};
            neg_q    <= left[WIDTH-1] ^ right[WIDTH-1];
            neg_l    <= left[WIDTH-1];
`ifndef FIXED_P_SDIV_SATURATE_EN
            left_cap <= left;
`endif
          end
        end
        // Iteration boundary: one quotient bit per edge, MSB first.
        RUN: begin
          dvd_sh <= dvd_nxt;
          rem    <= rem_nxt;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state         <= DONE;
            done          <= 1'b1;
            out_quotient  <= q_res;
            out_remainder <= r_res;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_p_std_sdiv_pipe.sv
module tb_fixed_p_std_sdiv_pipe;

  localparam int W  = 8;
  localparam int IW = 4;
  localparam int FW = 4;
  localparam int N  = W + FW;

  logic         clk = 1'b0;
  logic         reset;
  logic         go;
  logic [W-1:0] left;
  logic [W-1:0] right;
  logic [W-1:0] out_quotient;
  logic [W-1:0] out_remainder;
  logic         done;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] q, rm;
  int           lat;
  int           spurious;

  typedef struct {
    logic [7:0] l;
    logic [7:0] r;
    bit         meddle;
    logic [7:0] eq;
    logic [7:0] er;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  fixed_p_std_sdiv_pipe #(
    .WIDTH(W), .INT_WIDTH(IW), .FRACT_WIDTH(FW)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .left(left), .right(right),
    .out_quotient(out_quotient), .out_remainder(out_remainder), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain signed integer arithmetic on the scaled dividend.
  task automatic model(input logic [7:0] l, input logic [7:0] r,
                       output logic [7:0] eq, output logic [7:0] er);
    longint sl, sr, sc, qq, rr;
    sl = longint'($signed(l));
    sr = longint'($signed(r));
    sc = sl * (longint'(1) << FW);
    if (sr == 0) begin
`ifdef FIXED_P_SDIV_SATURATE_EN
      eq = (sl >= 0) ? 8'h7F : 8'h80;
      er = 8'h00;
`else
      eq = 8'hFF;
      er = l;
`endif
    end else begin
      qq = sc / sr;
      rr = sc % sr;
`ifdef FIXED_P_SDIV_SATURATE_EN
      if (qq > 127) begin
        eq = 8'h7F; er = 8'h00;
      end else if (qq < -128) begin
        eq = 8'h80; er = 8'h00;
      end else begin
        eq = 8'(qq); er = 8'(rr);
      end
`else
      eq = 8'(qq);
      er = 8'(rr);
`endif
    end
  endtask

  // Called at a negedge; go is presented immediately so back-to-back calls
  // start in the IDLE cycle right after DONE.
  task automatic run_op(input logic [7:0] l, input logic [7:0] r, input bit meddle,
                        output logic [7:0] oq, output logic [7:0] orm, output int olat);
    int extra;
    olat  = -1;
    left  = l;
    right = r;
    go    = 1'b1;
    for (int k = 0; k <= N + 4 && olat < 0; k++) begin
      @(negedge clk);
      if (done) olat = k;
      if (meddle) begin
        go    = 1'($urandom_range(0, 1));
        left  = 8'($urandom);
        right = 8'($urandom);
      end else begin
        go = 1'b0;
      end
    end
    oq  = out_quotient;
    orm = out_remainder;
    if (olat < 0) return;
    if (meddle) go = 1'b1;  // lands in the DONE cycle, must be ignored
    @(negedge clk);
    go = 1'b0;
    check("done_single_cycle", done, 0);
    check("q_hold", out_quotient, oq);
    check("r_hold", out_remainder, orm);
    if (meddle) begin
      extra = 0;
      repeat (N + 2) begin
        @(negedge clk);
        if (done) extra++;
      end
      check("no_extra_done", extra, 0);
    end
  endtask

  initial begin
    vecs[0] = '{8'h30, 8'h20, 1'b0, 8'h18, 8'h00};
    vecs[1] = '{8'hD0, 8'h20, 1'b0, 8'hE8, 8'h00};
    vecs[2] = '{8'hF0, 8'h30, 1'b0, 8'hFB, 8'hF0};
    vecs[3] = '{8'h10, 8'h30, 1'b1, 8'h05, 8'h10};
    vecs[4] = '{8'h80, 8'h10, 1'b0, 8'h80, 8'h00};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h10, 8'h00};
`ifdef FIXED_P_SDIV_SATURATE_EN
    vecs[6] = '{8'h70, 8'h01, 1'b0, 8'h7F, 8'h00};
    vecs[7] = '{8'h30, 8'h00, 1'b0, 8'h7F, 8'h00};
    vecs[8] = '{8'h80, 8'hF0, 1'b0, 8'h7F, 8'h00};
    vecs[9] = '{8'h80, 8'h00, 1'b0, 8'h80, 8'h00};
`else
    vecs[6] = '{8'h70, 8'h01, 1'b0, 8'h00, 8'h00};
    vecs[7] = '{8'h30, 8'h00, 1'b0, 8'hFF, 8'h30};
    vecs[8] = '{8'h80, 8'hF0, 1'b0, 8'h80, 8'h00};
    vecs[9] = '{8'h80, 8'h00, 1'b0, 8'hFF, 8'h80};
`endif

    reset = 1'b1;
    go    = 1'b0;
    left  = '0;
    right = '0;
    repeat (3) @(negedge clk);
    check("reset_done", done, 0);
    check("reset_q", out_quotient, 0);
    check("reset_r", out_remainder, 0);
    reset = 1'b0;

    // Directed vectors, issued back to back.
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].l, vecs[i].r, vecs[i].meddle, q, rm, lat);
      check($sformatf("vec%0d_latency", i), lat, N);
      check($sformatf("vec%0d_q", i), q, vecs[i].eq);
      check($sformatf("vec%0d_r", i), rm, vecs[i].er);
    end

    // Establish non-zero outputs, then reset five cycles into RUN with go high.
    run_op(8'h30, 8'h20, 1'b0, q, rm, lat);
    check("pre_reset_q", q, 8'h18);
    left = 8'h10; right = 8'h30; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    go    = 1'b1;
    @(negedge clk);
    check("midrun_reset_done", done, 0);
    check("midrun_reset_q", out_quotient, 0);
    check("midrun_reset_r", out_remainder, 0);
    @(negedge clk);
    go = 1'b0;
    reset = 1'b0;
    spurious = 0;
    repeat (N + 3) begin
      @(negedge clk);
      if (done) spurious++;
    end
    check("reset_kills_op", spurious, 0);
    check("reset_idle_q", out_quotient, 0);

    // go presented on the very first edge with reset released.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    run_op(8'hF0, 8'h30, 1'b0, q, rm, lat);
    check("post_reset_latency", lat, N);
    check("post_reset_q", q, 8'hFB);
    check("post_reset_r", rm, 8'hF0);

    // Randomized operands against the arithmetic reference.
    for (int i = 0; i < 150; i++) begin
      logic [7:0] l, r, eq, er;
      l = 8'($urandom);
      r = 8'($urandom);
      case ($urandom_range(0, 9))
        0: r = 8'h00;
        1: l = 8'h80;
        2: r = 8'h80;
        3: r = 8'($urandom_range(1, 3));
        default: ;
      endcase
      model(l, r, eq, er);
      run_op(l, r, (i % 10) == 0, q, rm, lat);
      check($sformatf("rnd%0d_latency l=%0h r=%0h", i, l, r), lat, N);
      check($sformatf("rnd%0d_q l=%0h r=%0h", i, l, r), q, eq);
      check($sformatf("rnd%0d_r l=%0h r=%0h", i, l, r), rm, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
